// File: rtl/main_mem_resp.sv
// main_mem_resp: word-addressed on-chip memory with a fixed-latency read
// response path.
//
// After reset the block sweeps the whole array to zero, one word per cycle,
// while mem_busy is high. It then accepts one request per cycle with no
// stalls. Reads return data RD_LAT cycles after the request edge.
// Rejected accesses pulse mem_err RD_LAT cycles after the request edge.
//
// Parameters
//   MEM_DEPTH : number of 32-bit words, a power of two in 16..65536
//   RD_LAT    : read/error latency in cycles, 1..4
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous, active-high reset
//   mem_cs       : request strobe; one request per cycle while high
//   mem_wen      : 1 = write, 0 = read (qualified by mem_cs)
//   mem_addr     : byte address; bits [1:0] are ignored
//   mem_dat_in   : write data
//   mem_dat_out  : read data, held between read responses
//   mem_rvalid   : one-cycle pulse, mem_dat_out carries a new read result
//   mem_err      : one-cycle pulse, a request was rejected
//   mem_busy     : high while the clearing sweep runs
//   dbg_state    : FSM state (0 = INIT, 1 = READY)
//   dbg_init_ptr : clearing-sweep word index
//
// Handshake: there is no ready signal. Every cycle with mem_cs=1 is one
// request and is always accepted. Each read, and each rejected access,
// yields exactly one response cycle RD_LAT cycles later. On that cycle
// mem_rvalid and/or mem_err are high. Writes that land produce no response.
module main_mem_resp #(
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_cs,
  input  logic                         mem_wen,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_dat_in,
  output logic [31:0]                  mem_dat_out,
  output logic                         mem_rvalid,
  output logic                         mem_err,
  output logic                         mem_busy,
  output logic                         dbg_state,
  output logic [$clog2(MEM_DEPTH)-1:0] dbg_init_ptr
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] init_ptr;

  logic [31:0]   mem [MEM_DEPTH];

  logic          in_range;
  logic [AW-1:0] idx;
  logic          unused_addr_lsbs;

  assign in_range         = mem_addr[31:2] < 30'(MEM_DEPTH);
  assign idx              = mem_addr[2 +: AW];
  assign unused_addr_lsbs = ^mem_addr[1:0];

  // INIT/READY sequencing. READY is only left through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else if (state == ST_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == AW'(MEM_DEPTH - 1)) begin
        state <= ST_READY;
      end
    end
  end

  // Single write port shared by the clearing sweep and initiator writes.
  // Nothing is written while rst is high.
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_ptr;
    mem_wdata = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        mem_we = 1'b1;
      end else if (mem_cs && mem_wen && in_range) begin
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = mem_dat_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Response decode for the request on this edge. Any access during INIT
  // is an error. An out-of-range read is both valid (data 0) and an error.
  // An out-of-range write is an error only.
  logic        req_v;
  logic        req_e;
  logic [31:0] req_d;

  assign req_v = (state == ST_READY) && mem_cs && !mem_wen;
  assign req_e = mem_cs && ((state != ST_READY) || !in_range);
  assign req_d = in_range ? mem[idx] : '0;

  // RD_LAT-deep response pipeline. Stage 0 captures at the request edge, so
  // the last stage drives the outputs RD_LAT cycles after the request edge.
  // Only the last data stage holds its value when no read result arrives.
  logic [RD_LAT-1:0]       pv;
  logic [RD_LAT-1:0]       pe;
  logic [RD_LAT-1:0][31:0] pd;
  logic [RD_LAT-1:0]       src_v;
  logic [RD_LAT-1:0]       src_e;
  logic [RD_LAT-1:0][31:0] src_d;

  always_comb begin
    src_v[0] = req_v;
    src_e[0] = req_e;
    src_d[0] = req_d;
    for (int i = 1; i < RD_LAT; i++) begin
      src_v[i] = pv[i-1];
      src_e[i] = pe[i-1];
      src_d[i] = pd[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= src_v[i];
        pe[i] <= src_e[i];
        if ((i != RD_LAT - 1) || src_v[i]) begin
          pd[i] <= src_d[i];
        end
      end
    end
  end

  assign mem_rvalid   = pv[RD_LAT-1];
  assign mem_err      = pe[RD_LAT-1];
  assign mem_dat_out  = pd[RD_LAT-1];
  assign mem_busy     = rst || (state == ST_INIT);
  assign dbg_state    = state;
  assign dbg_init_ptr = init_ptr;

endmodule

// File: tb/tb_main_mem_resp.sv
// Bench for main_mem_resp. Three instances (RD_LAT = 1, 2, 3, MEM_DEPTH = 16)
// share one set of inputs. A behavioural model computes each request's
// response, and the model's responses are delayed by each instance's latency.
module tb_main_mem_resp;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic        r;
    logic        cs;
    logic        wen;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        = 1'b1;
  logic        mem_cs     = 1'b0;
  logic        mem_wen    = 1'b0;
  logic [31:0] mem_addr   = '0;
  logic [31:0] mem_dat_in = '0;

  logic [31:0] act_d    [3];
  logic        act_v    [3];
  logic        act_e    [3];
  logic        act_busy [3];
  logic        act_st   [3];
  logic [3:0]  act_ptr  [3];

  main_mem_resp #(.MEM_DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(act_d[0]), .mem_rvalid(act_v[0]), .mem_err(act_e[0]),
    .mem_busy(act_busy[0]), .dbg_state(act_st[0]), .dbg_init_ptr(act_ptr[0])
  );

  main_mem_resp #(.MEM_DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(act_d[1]), .mem_rvalid(act_v[1]), .mem_err(act_e[1]),
    .mem_busy(act_busy[1]), .dbg_state(act_st[1]), .dbg_init_ptr(act_ptr[1])
  );

  main_mem_resp #(.MEM_DEPTH(DEPTH), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(act_d[2]), .mem_rvalid(act_v[2]), .mem_err(act_e[2]),
    .mem_busy(act_busy[2]), .dbg_state(act_st[2]), .dbg_init_ptr(act_ptr[2])
  );

  // scoreboard / reference model
  logic [33:0] exp_q[$];            // {rvalid, err, data} per request edge
  logic [31:0] mem_m [DEPTH];
  logic        exp_v [3];
  logic        exp_e [3];
  logic [31:0] exp_d [3];
  logic        exp_busy;
  int          busy_left;
  int          cyc;
  int          n_checks;
  int          n_errors;

  function automatic req_t rq(logic r, logic cs, logic wen, logic [31:0] a, logic [31:0] d);
    return {r, cs, wen, a, d};
  endfunction

  // Driver: apply one cycle of stimulus, then advance the model to what every
  // instance must show just after that edge.
  task automatic drive(input req_t q);
    logic [33:0] resp;
    rst        = q.r;
    mem_cs     = q.cs;
    mem_wen    = q.wen;
    mem_addr   = q.a;
    mem_dat_in = q.d;
    @(posedge clk);
    cyc++;
    if (q.r) begin
      exp_q.delete();
      busy_left = DEPTH;
      foreach (mem_m[k]) mem_m[k] = '0;   // contents once the sweep completes
      for (int l = 0; l < 3; l++) begin
        exp_v[l] = 1'b0;
        exp_e[l] = 1'b0;
        exp_d[l] = '0;
      end
    end else begin
      resp = '0;
      if (busy_left > 0) begin
        resp[32] = q.cs;
        busy_left--;
      end else if (q.cs) begin
        if (q.a[31:2] >= 30'(DEPTH)) begin
          resp[33] = !q.wen;
          resp[32] = 1'b1;
        end else if (q.wen) begin
          mem_m[q.a[5:2]] = q.d;
        end else begin
          resp = {2'b10, mem_m[q.a[5:2]]};
        end
      end
      exp_q.push_back(resp);
      if (exp_q.size() > 4) void'(exp_q.pop_front());
      for (int l = 0; l < 3; l++) begin
        if (exp_q.size() >= l + 1) resp = exp_q[exp_q.size() - (l + 1)];
        else                       resp = '0;
        exp_v[l] = resp[33];
        exp_e[l] = resp[32];
        if (resp[33]) exp_d[l] = resp[31:0];
      end
    end
    exp_busy = q.r || (busy_left > 0);
    #1;
  endtask

  task automatic test_init;
    req_t s[$];
    int   busy_cnt;
    busy_cnt = 0;
    s.push_back(rq(1, 0, 0, 32'h0, 32'h0));
    s.push_back(rq(1, 0, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h0, 32'h0));        // read while busy
    for (int i = 0; i < 19; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h3C, 32'h0));
    for (int i = 0; i < 3; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      if (i >= 1 && act_busy[0] === 1'b1) busy_cnt++;
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL init lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
        n_checks++;
        if (act_busy[l] !== exp_busy) begin
          n_errors++;
          $display("FAIL init_busy lat%0d cyc%0d: got %b want %b", l + 1, cyc, act_busy[l], exp_busy);
        end
      end
    end
    n_checks++;
    if (busy_cnt != DEPTH) begin
      n_errors++;
      $display("FAIL busy_length: got %0d cycles want %0d", busy_cnt, DEPTH);
    end
  endtask

  task automatic test_write_read_next;
    req_t s[$];
    s.push_back(rq(0, 1, 1, 32'h10, 32'hCAFEF00D));
    s.push_back(rq(0, 1, 0, 32'h10, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h13, 32'h0));        // byte offset ignored
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL write_read lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    req_t s[$];
    s.push_back(rq(0, 1, 1, 32'h0, 32'h11));
    s.push_back(rq(0, 1, 1, 32'h4, 32'h22));
    s.push_back(rq(0, 1, 1, 32'h8, 32'h33));
    s.push_back(rq(0, 1, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h4, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h8, 32'h0));
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL back_to_back lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    req_t s[$];
    s.push_back(rq(0, 1, 1, 32'h0, 32'h0000_1234));
    s.push_back(rq(0, 1, 1, 32'h40, 32'hFFFFFFFF));   // would alias word 0
    s.push_back(rq(0, 1, 0, 32'h40, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h8000_0000, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h3C, 32'h0));
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL out_of_range lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
      end
    end
  endtask

  task automatic test_cs_low;
    req_t s[$];
    s.push_back(rq(0, 1, 1, 32'h8, 32'hA5A5_0008));
    s.push_back(rq(0, 1, 0, 32'h8, 32'h0));
    for (int i = 0; i < 3; i++) s.push_back(rq(0, 0, 1, 32'h8, 32'h55));
    s.push_back(rq(0, 0, 0, 32'h44, 32'h77));
    s.push_back(rq(0, 0, 1, $urandom, $urandom));
    s.push_back(rq(0, 1, 0, 32'h8, 32'h0));
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL cs_low lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
      end
    end
  endtask

  task automatic test_random;
    req_t        s[$];
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = {26'($urandom_range(0, 23)), 2'($urandom_range(0, 3)), 4'b0} >> 2;
      a = {a[29:0], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 19) == 0) a[31] = 1'b1;
      s.push_back(rq(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom));
    end
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL random lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flight;
    req_t s[$];
    s.push_back(rq(0, 1, 1, 32'h0, 32'hDEAD_BEEF));
    s.push_back(rq(0, 1, 0, 32'h0, 32'h0));         // in flight when rst hits
    s.push_back(rq(1, 0, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 1, 32'h4, 32'h9999_9999)); // ignored during INIT
    for (int i = 0; i < 18; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h0, 32'h0));
    s.push_back(rq(0, 1, 0, 32'h4, 32'h0));
    for (int i = 0; i < 4; i++) s.push_back(rq(0, 0, 0, 32'h0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      for (int l = 0; l < 3; l++) begin
        n_checks++;
        if ({act_v[l], act_e[l], act_d[l]} !== {exp_v[l], exp_e[l], exp_d[l]}) begin
          n_errors++;
          $display("FAIL reset_mid lat%0d cyc%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   l + 1, cyc, act_v[l], act_e[l], act_d[l], exp_v[l], exp_e[l], exp_d[l]);
        end
        n_checks++;
        if ({act_busy[l], act_st[l]} !== {exp_busy, busy_left == 0}) begin
          n_errors++;
          $display("FAIL reset_state lat%0d cyc%0d: got busy=%b st=%b want busy=%b st=%b",
                   l + 1, cyc, act_busy[l], act_st[l], exp_busy, busy_left == 0);
        end
        if (i >= 2 && busy_left > 0) begin
          n_checks++;
          if (act_ptr[l] !== 4'(DEPTH - busy_left)) begin
            n_errors++;
            $display("FAIL init_ptr lat%0d cyc%0d: got %0d want %0d",
                     l + 1, cyc, act_ptr[l], DEPTH - busy_left);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    busy_left = DEPTH;
    exp_busy  = 1'b1;
    test_init();
    test_write_read_next();
    test_back_to_back();
    test_out_of_range();
    test_cs_low();
    test_random();
    test_reset_mid_flight();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
